c64_bus_arbiter: RTL
====================

Name: c64_bus_arbiter

Overview:
- Shares the single system memory bus between the 6502 CPU core and the VIC-II video fetch engine.
- Models C64 BA/AEC semantics:
  - VIC request drops BA, then allows STALL_CYCLES cycles in which CPU writes may complete.
  - VIC then owns the bus until it releases it.
- Drives the muxed memory address, data and write enable, plus a ready/stall signal back to the CPU sequencer.

Parameters:
- STALL_CYCLES, 3, cycles from BA falling to VIC grant; legal range 1..15.
- ADDR_W, 16, memory address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_ab  input  ADDR_W  CPU address.
- cpu_do  input  8  CPU write data.
- cpu_we  input  1  CPU write enable.
- cpu_rdy  output  1  1 = CPU may complete the current cycle; 0 = CPU must hold state.
- vic_req  input  1  VIC requests the bus; held high for the whole fetch burst.
- vic_ab  input  ADDR_W  VIC fetch address.
- vic_grant  output  1  VIC owns the bus this cycle; read data is valid for the VIC.
- ba  output  1  bus available; 0 warns the CPU that a steal is pending or active.
- mem_ab  output  ADDR_W  memory address.
- mem_do  output  8  memory write data.
- mem_we  output  1  memory write enable.
- stolen_cycles  output  16  present only with ARB_STATS_EN.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- States: CPU_OWN, BA_WAIT, VIC_OWN, RELEASE. The state register and 4-bit stall counter cnt are updated on posedge clk or posedge reset.
- Reset values:
  - state=CPU_OWN, cnt=0.
  - Outputs: ba=1, vic_grant=0, cpu_rdy=1, mem_ab=cpu_ab, mem_do=cpu_do, mem_we=cpu_we, stolen_cycles=0.
- Outputs are combinational from the registered state and the current inputs; pass-through latency is 0.
- CPU_OWN:
  - mem_* = cpu_*, ba=1, cpu_rdy=1, vic_grant=0.
  - vic_req=1 -> BA_WAIT with cnt=STALL_CYCLES-1.
- BA_WAIT:
  - ba=0; mem_* = cpu_*.
  - cpu_rdy = cpu_we, i.e. writes complete and reads stall.
  - mem_we=cpu_we, so writes still reach memory.
  - cnt==0 -> VIC_OWN; otherwise cnt decrements.
  - vic_req=0 (aborted request) -> CPU_OWN immediately; the abort has priority over the count.
- VIC_OWN:
  - mem_ab=vic_ab, mem_we=0, mem_do=cpu_do (don't-care); vic_grant=1, ba=0, cpu_rdy=0.
  - vic_req=0 -> RELEASE.
- RELEASE:
  - One turnaround cycle: mem_ab=cpu_ab, mem_we=0, ba=0, vic_grant=0, cpu_rdy=0.
  - Always goes to CPU_OWN next.
  - A vic_req re-asserted during RELEASE is not serviced until CPU_OWN; from there it goes to BA_WAIT on the following edge.
- Grant latency from vic_req rising in CPU_OWN: vic_grant=1 exactly STALL_CYCLES+1 edges later.
- The CPU never writes while vic_grant=1. mem_we=1 is possible only in CPU_OWN or BA_WAIT.
- Reset mid-burst: immediately CPU_OWN with ba=1. An in-flight VIC fetch is dropped without notice.
- A vic_req glitch shorter than one cycle between edges is ignored; only sampled values matter.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds stolen_cycles[15:0], incrementing on every edge where the state is VIC_OWN or RELEASE, or BA_WAIT with cpu_we=0.
  - Saturates at 16'hFFFF and is cleared by reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package c64_bus_pkg:
  - Arbiter state encoding constants: CPU_OWN=2'd0, BA_WAIT=2'd1, VIC_OWN=2'd2, RELEASE=2'd3.
  - DEFAULT_STALL_CYCLES=3.
  - Bus owner enum, reused by the future CIA/colour-RAM decoders.
- One sub-module is natural: c64_ba_countdown.
  - Loadable 4-bit down counter with a zero flag.
  - Reused for the sprite DMA steal windows.
- The mux and FSM stay in the top level.

Test Plan:
- Reset pulsed mid-VIC_OWN (vic_req=1) -> ba=1, vic_grant=0, mem_ab=cpu_ab at once; grant reappears 4 edges after reset release.
- cpu_ab=16'h1234, cpu_we=1, cpu_do=8'hA5, vic_req=0 -> mem_ab=16'h1234, mem_we=1, mem_do=8'hA5, cpu_rdy=1 every cycle.
- vic_req rises at edge N with STALL_CYCLES=3 and a CPU read pending:
  - ba=0 from edge N; cpu_rdy=0 from edge N.
  - vic_grant=1 from edge N+3; mem_ab=vic_ab=16'h0400.
- Same request while the CPU writes 8'h55 to 16'h00FF during BA_WAIT -> mem_we=1 and cpu_rdy=1 through BA_WAIT; mem_we=0 once vic_grant=1.
- vic_req drops after 2 BA_WAIT cycles -> CPU_OWN next edge, ba=1, vic_grant never asserted.
- vic_req held for 40 grant cycles then dropped:
  - One RELEASE cycle with mem_we=0, then ba=1.
  - With ARB_STATS_EN and the CPU reading throughout: stolen_cycles=3+40+1=44.

Source files
------------

// File: rtl/c64_bus_pkg.sv
// Shared types and constants for the C64 system-bus arbitration logic.
// Contents: arbiter state encoding, stall-counter width, default BA-to-AEC
// stall, statistics width and the bus-owner enum used by the address decoders.
package c64_bus_pkg;

  localparam int unsigned CNT_W                = 4;
  localparam int unsigned DEFAULT_STALL_CYCLES = 3;
  localparam int unsigned STATS_W              = 16;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    BA_WAIT = 2'd1,
    VIC_OWN = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_VIC = 1'b1
  } bus_owner_e;

  // Which master drives the address bus in a given arbiter state.
  function automatic bus_owner_e owner_of(input arb_state_e s);
    return (s == VIC_OWN) ? OWNER_VIC : OWNER_CPU;
  endfunction

endpackage

// File: rtl/c64_ba_countdown.sv
// Loadable down counter with a zero flag; times the BA-low window before a
// DMA master takes the bus.
// Ports: clk, reset (async, active-high), load/load_val (load has priority),
// dec (decrement, holds at zero), zero_c (combinational count==0 flag).
module c64_ba_countdown
  import c64_bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero_c) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/c64_bus_arbiter.sv
// Arbitrates the system memory bus between the 6502 core and the VIC-II
// fetch engine with C64 BA/AEC semantics: BA drops on a VIC request, CPU
// writes may finish during the stall window, then the VIC owns the bus
// until it releases it, followed by one turnaround cycle.
// Ports: clk, reset (async, active-high); cpu_ab/cpu_do/cpu_we from the CPU,
// cpu_rdy back to its sequencer; vic_req/vic_ab from the VIC, vic_grant back;
// ba; muxed mem_ab/mem_do/mem_we. All outputs are combinational from the
// registered state and current inputs.
// Build option: define ARB_STATS_EN to add the stolen_cycles counter port.
module c64_bus_arbiter
  import c64_bus_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = DEFAULT_STALL_CYCLES,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic [7:0]        cpu_do,
  input  logic              cpu_we,
  output logic              cpu_rdy,
  input  logic              vic_req,
  input  logic [ADDR_W-1:0] vic_ab,
  output logic              vic_grant,
  output logic              ba,
  output logic [ADDR_W-1:0] mem_ab,
  output logic [7:0]        mem_do,
  output logic              mem_we
`ifdef ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] stolen_cycles
`endif
);

  arb_state_e state;
  logic       cnt_load_c;
  logic       cnt_dec_c;
  logic       cnt_zero_c;

  // Counter is armed on the request edge and only runs while the request holds.
  assign cnt_load_c = (state == CPU_OWN) && vic_req;
  assign cnt_dec_c  = (state == BA_WAIT) && vic_req;

  c64_ba_countdown u_countdown (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_c),
    .load_val (CNT_W'(STALL_CYCLES - 1)),
    .dec      (cnt_dec_c),
    .zero_c   (cnt_zero_c)
  );

  // State register; a dropped request in BA_WAIT beats an expiring count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CPU_OWN;
    end else begin
      case (state)
        CPU_OWN: if (vic_req) state <= BA_WAIT;
        BA_WAIT: begin
          if (!vic_req)        state <= CPU_OWN;
          else if (cnt_zero_c) state <= VIC_OWN;
        end
        VIC_OWN: if (!vic_req) state <= RELEASE;
        RELEASE: state <= CPU_OWN;
        default: state <= CPU_OWN;
      endcase
    end
  end

  // Bus mux and handshake outputs; only the VIC state swaps the address.
  always_comb begin
    ba        = 1'b1;
    vic_grant = 1'b0;
    cpu_rdy   = 1'b1;
    mem_do    = cpu_do;
    mem_we    = cpu_we;
    mem_ab    = (owner_of(state) == OWNER_VIC) ? vic_ab : cpu_ab;
    case (state)
      CPU_OWN: ;
      BA_WAIT: begin
        ba      = 1'b0;
        cpu_rdy = cpu_we;
      end
      VIC_OWN: begin
        ba        = 1'b0;
        vic_grant = 1'b1;
        cpu_rdy   = 1'b0;
        mem_we    = 1'b0;
      end
      RELEASE: begin
        ba      = 1'b0;
        cpu_rdy = 1'b0;
        mem_we  = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef ARB_STATS_EN
  logic steal_c;

  // A cycle is stolen whenever the CPU cannot make progress on the bus.
  assign steal_c = (state == VIC_OWN) || (state == RELEASE) ||
                   ((state == BA_WAIT) && !cpu_we);

  // Saturating stolen-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stolen_cycles <= '0;
    end else if (steal_c && (stolen_cycles != {STATS_W{1'b1}})) begin
      stolen_cycles <= stolen_cycles + STATS_W'(1);
    end
  end
`endif

endmodule
